// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register and control stage.
// Registers the ALU result and EX side-band fields into the MEM slot. Owns the
// S/Z/C/V flag register that feeds back into the ALU. Kills wrong-path slots
// after a taken branch and sequences the processor into a halted state.
module ex_mem_stage #(
  parameter int FLUSH_DEPTH  = 2,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [1:0]  ex_op1,
  input  logic [2:0]  ex_op2,
  input  logic [3:0]  ex_opcode,
  input  logic [2:0]  ex_rd,
  input  logic [15:0] ex_store_data,
  input  logic [15:0] alu_out,
  input  logic        alu_s,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        alu_hlt,
  input  logic        alu_flush,
  input  logic        mem_stall,
  output logic        flag_s,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_v,
  output logic        mem_valid,
  output logic [15:0] mem_result,
  output logic [15:0] mem_store_data,
  output logic [2:0]  mem_rd,
  output logic        mem_reg_we,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic        branch_taken,
  output logic [15:0] branch_target,
  output logic        halt_req,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH);
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES);

  state_t     state_reg;
  logic [2:0] sq_cnt_reg;
  logic [2:0] drain_cnt_reg;

  logic accept;
  logic live;
  logic flush_take;
  logic halt_take;
  logic reg_we_dec;
  logic rd_en_dec;
  logic wr_en_dec;

  // Handshake: the only things that block the slot are a halted core or MEM backpressure.
  assign ex_ready = (state_reg != ST_HALTED) && !mem_stall;
  assign accept   = ex_ready && !mem_stall;

  // A slot is live only when accepted, valid, not inside a squash window and the core is running.
  assign live = accept && ex_valid && (sq_cnt_reg == 3'd0) && (state_reg == ST_RUN);

  // Flush wins over halt if both are raised; squashed slots never reach here because live is low.
  assign flush_take = live && alu_flush;
  assign halt_take  = live && alu_hlt && !alu_flush;

  // Instruction-class decode for the MEM-stage enables.
  always_comb begin
    reg_we_dec = 1'b0;
    rd_en_dec  = 1'b0;
    wr_en_dec  = 1'b0;
    case (ex_op1)
      2'b00: begin
        rd_en_dec  = 1'b1;
        reg_we_dec = 1'b1;
      end
      2'b01: begin
        wr_en_dec = 1'b1;
      end
      2'b10: begin
        reg_we_dec = (ex_op2 == 3'b000) || (ex_op2 == 3'b001) || (ex_op2 == 3'b010);
      end
      default: begin
        // op1 == 11: compares, branches-by-opcode and HLT do not write back
        reg_we_dec = !((ex_opcode == 4'd5)  || (ex_opcode == 4'd7) ||
                       (ex_opcode == 4'd13) || (ex_opcode == 4'd14) ||
                       (ex_opcode == 4'd15));
      end
    endcase
  end

  // Architectural flag register: written only by live, non-halting slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_s <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (live && !halt_take) begin
      flag_s <= alu_s;
      flag_z <= alu_z;
      flag_c <= alu_c;
      flag_v <= alu_v;
    end
  end

  // MEM pipeline register: loads on every accept, holds during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_result     <= 16'h0000;
      mem_store_data <= 16'h0000;
      mem_rd         <= 3'd0;
      mem_reg_we     <= 1'b0;
      mem_rd_en      <= 1'b0;
      mem_wr_en      <= 1'b0;
    end else if (accept) begin
      mem_valid      <= live && !halt_take;
      mem_result     <= alu_out;
      mem_store_data <= ex_store_data;
      mem_rd         <= ex_rd;
      mem_reg_we     <= live && reg_we_dec;
      mem_rd_en      <= live && rd_en_dec;
      mem_wr_en      <= live && wr_en_dec;
    end
  end

  // Branch redirect: single-cycle pulse, target held until the next taken branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_taken  <= 1'b0;
      branch_target <= 16'h0000;
    end else begin
      branch_taken <= flush_take;
      if (flush_take) begin
        branch_target <= alu_out;
      end
    end
  end

  // Squash window: counts accepted slots (valid or bubble) after a taken branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_cnt_reg <= 3'd0;
    end else if (flush_take) begin
      sq_cnt_reg <= FLUSH_LOAD;
    end else if (accept && (sq_cnt_reg != 3'd0)) begin
      sq_cnt_reg <= sq_cnt_reg - 3'd1;
    end
  end

  // Halt sequencer: RUN -> DRAIN on a live HLT, DRAIN counts down regardless of stalls, then HALTED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      drain_cnt_reg <= 3'd0;
      halt_req      <= 1'b0;
      halted        <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (halt_take) begin
            state_reg     <= ST_DRAIN;
            drain_cnt_reg <= DRAIN_LOAD;
            halt_req      <= 1'b1;
          end
        end
        ST_DRAIN: begin
          halt_req <= 1'b1;
          if (drain_cnt_reg <= 3'd1) begin
            drain_cnt_reg <= 3'd0;
            state_reg     <= ST_HALTED;
            halted        <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - 3'd1;
          end
        end
        ST_HALTED: begin
          halt_req <= 1'b1;
          halted   <= 1'b1;
        end
        default: begin
          state_reg <= ST_RUN;
          halt_req  <= 1'b0;
          halted    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed EX slots with hand-computed MEM/flag
// expectations pushed to a scoreboard queue; a monitor pops one entry per
// accepted valid slot and compares the registered outputs.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_op1;
  logic [2:0]  ex_op2;
  logic [3:0]  ex_opcode;
  logic [2:0]  ex_rd;
  logic [15:0] ex_store_data;
  logic [15:0] alu_out;
  logic        alu_s, alu_z, alu_c, alu_v;
  logic        alu_hlt;
  logic        alu_flush;
  logic        mem_stall;
  logic        flag_s, flag_z, flag_c, flag_v;
  logic        mem_valid;
  logic [15:0] mem_result;
  logic [15:0] mem_store_data;
  logic [2:0]  mem_rd;
  logic        mem_reg_we, mem_rd_en, mem_wr_en;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt_req;
  logic        halted;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [1:0]  op1;
    logic [2:0]  op2;
    logic [3:0]  opcode;
    logic [2:0]  rd;
    logic [15:0] sd;
    logic [15:0] aout;
    logic [3:0]  szcv;
    logic        hlt;
    logic        flush;
  } stim_t;

  typedef struct packed {
    logic        mv;
    logic [15:0] res;
    logic [15:0] sd;
    logic [2:0]  rd;
    logic        we;
    logic        rde;
    logic        wre;
    logic [3:0]  flags;
    logic        bt;
    logic [15:0] btgt;
    logic        hreq;
  } exp_t;

  exp_t exp_q[$];

  ex_mem_stage #(.FLUSH_DEPTH(2), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
    .ex_store_data(ex_store_data), .alu_out(alu_out),
    .alu_s(alu_s), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .alu_hlt(alu_hlt), .alu_flush(alu_flush), .mem_stall(mem_stall),
    .flag_s(flag_s), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_store_data(mem_store_data),
    .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .halt_req(halt_req), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    else passes++;
  endfunction

  function automatic stim_t st(logic [1:0] op1, logic [2:0] op2, logic [3:0] opcode,
                               logic [2:0] rd, logic [15:0] sd, logic [15:0] aout,
                               logic [3:0] szcv, logic hlt, logic flush);
    return '{op1, op2, opcode, rd, sd, aout, szcv, hlt, flush};
  endfunction

  function automatic exp_t ex(logic mv, logic [15:0] res, logic [15:0] sd, logic [2:0] rd,
                              logic we, logic rde, logic wre, logic [3:0] flags,
                              logic bt, logic [15:0] btgt, logic hreq);
    return '{mv, res, sd, rd, we, rde, wre, flags, bt, btgt, hreq};
  endfunction

  task automatic drive(stim_t s);
    ex_valid      = 1'b1;
    ex_op1        = s.op1;
    ex_op2        = s.op2;
    ex_opcode     = s.opcode;
    ex_rd         = s.rd;
    ex_store_data = s.sd;
    alu_out       = s.aout;
    {alu_s, alu_z, alu_c, alu_v} = s.szcv;
    alu_hlt       = s.hlt;
    alu_flush     = s.flush;
  endtask

  // Present one slot, queue its expected MEM-side result, wait for the accepting edge.
  task automatic issue(stim_t s, exp_t e);
    drive(s);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  // Monitor: every edge that accepted a valid slot produces one comparison set.
  initial begin : monitor
    logic acc;
    exp_t e;
    forever begin
      @(negedge clk);
      acc = rst_n && ex_valid && ex_ready;
      @(posedge clk);
      #2;
      if (acc && rst_n) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_accept", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("txn: mv=%0b res=%04h sd=%04h rd=%0d we=%0b rd_en=%0b wr_en=%0b flags=%04b bt=%0b tgt=%04h hreq=%0b",
                   mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_we, mem_rd_en,
                   mem_wr_en, {flag_s, flag_z, flag_c, flag_v}, branch_taken, branch_target, halt_req);
          chk("mem_valid",      32'(mem_valid),      32'(e.mv));
          chk("mem_result",     32'(mem_result),     32'(e.res));
          chk("mem_store_data", 32'(mem_store_data), 32'(e.sd));
          chk("mem_rd",         32'(mem_rd),         32'(e.rd));
          chk("mem_reg_we",     32'(mem_reg_we),     32'(e.we));
          chk("mem_rd_en",      32'(mem_rd_en),      32'(e.rde));
          chk("mem_wr_en",      32'(mem_wr_en),      32'(e.wre));
          chk("flags",          32'({flag_s, flag_z, flag_c, flag_v}), 32'(e.flags));
          chk("branch_taken",   32'(branch_taken),   32'(e.bt));
          chk("branch_target",  32'(branch_target),  32'(e.btgt));
          chk("halt_req",       32'(halt_req),       32'(e.hreq));
        end
      end
    end
  end

  initial begin : stimulus
    // Reset with random inputs: every output must read zero
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ex_valid      = 1'($urandom);
      ex_op1        = 2'($urandom);
      ex_op2        = 3'($urandom);
      ex_opcode     = 4'($urandom);
      ex_rd         = 3'($urandom);
      ex_store_data = 16'($urandom);
      alu_out       = 16'($urandom);
      {alu_s, alu_z, alu_c, alu_v} = 4'($urandom);
      alu_hlt       = 1'($urandom);
      alu_flush     = 1'($urandom);
      mem_stall     = 1'($urandom);
      @(posedge clk);
      #2;
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_mem_result", 32'(mem_result), 32'd0);
      chk("rst_flags", 32'({flag_s, flag_z, flag_c, flag_v}), 32'd0);
      chk("rst_branch", 32'({branch_taken, branch_target}), 32'd0);
      chk("rst_halt", 32'({halt_req, halted}), 32'd0);
    end
    ex_valid  = 1'b0;
    alu_hlt   = 1'b0;
    alu_flush = 1'b0;
    mem_stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD, CMP, LI (ALU passes flags through), LD
    issue(st(2'b11, 3'd0, 4'd0, 3'd1, 16'h0000, 16'h0005, 4'b0010, 0, 0),
          ex(1, 16'h0005, 16'h0000, 3'd1, 1, 0, 0, 4'b0010, 0, 16'h0000, 0));
    issue(st(2'b11, 3'd0, 4'd5, 3'd2, 16'h0000, 16'h0000, 4'b0100, 0, 0),
          ex(1, 16'h0000, 16'h0000, 3'd2, 0, 0, 0, 4'b0100, 0, 16'h0000, 0));
    issue(st(2'b10, 3'b000, 4'd0, 3'd3, 16'h0000, 16'h0033, 4'b0100, 0, 0),
          ex(1, 16'h0033, 16'h0000, 3'd3, 1, 0, 0, 4'b0100, 0, 16'h0000, 0));
    issue(st(2'b00, 3'd0, 4'd0, 3'd2, 16'h0000, 16'h0100, 4'b0100, 0, 0),
          ex(1, 16'h0100, 16'h0000, 3'd2, 1, 1, 0, 4'b0100, 0, 16'h0000, 0));

    // Taken branch, two squashed slots (flags/flush ignored), then a live slot
    issue(st(2'b10, 3'b100, 4'd0, 3'd0, 16'h0000, 16'h0040, 4'b0100, 0, 1),
          ex(1, 16'h0040, 16'h0000, 3'd0, 0, 0, 0, 4'b0100, 1, 16'h0040, 0));
    issue(st(2'b11, 3'd0, 4'd0, 3'd4, 16'h0000, 16'h0077, 4'b1111, 0, 1),
          ex(0, 16'h0077, 16'h0000, 3'd4, 0, 0, 0, 4'b0100, 0, 16'h0040, 0));
    issue(st(2'b11, 3'd0, 4'd0, 3'd5, 16'h0000, 16'h0088, 4'b1111, 0, 1),
          ex(0, 16'h0088, 16'h0000, 3'd5, 0, 0, 0, 4'b0100, 0, 16'h0040, 0));
    issue(st(2'b11, 3'd0, 4'd0, 3'd6, 16'h0000, 16'h0009, 4'b0000, 0, 0),
          ex(1, 16'h0009, 16'h0000, 3'd6, 1, 0, 0, 4'b0000, 0, 16'h0040, 0));

    // Branch, one squashed slot, then a 3-cycle stall with one squash slot pending
    issue(st(2'b10, 3'b101, 4'd0, 3'd0, 16'h0000, 16'h0050, 4'b0000, 0, 1),
          ex(1, 16'h0050, 16'h0000, 3'd0, 0, 0, 0, 4'b0000, 1, 16'h0050, 0));
    issue(st(2'b11, 3'd0, 4'd0, 3'd1, 16'h0000, 16'h00AA, 4'b1111, 0, 0),
          ex(0, 16'h00AA, 16'h0000, 3'd1, 0, 0, 0, 4'b0000, 0, 16'h0050, 0));
    drive(st(2'b11, 3'd0, 4'd0, 3'd2, 16'h0000, 16'h00BB, 4'b1111, 0, 0));
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ex_ready", 32'(ex_ready), 32'd0);
      @(posedge clk);
      #2;
      chk("stall_mem_result", 32'(mem_result), 32'h00AA);
      chk("stall_mem_valid", 32'(mem_valid), 32'd0);
    end
    mem_stall = 1'b0;
    issue(st(2'b11, 3'd0, 4'd0, 3'd2, 16'h0000, 16'h00BB, 4'b1111, 0, 0),
          ex(0, 16'h00BB, 16'h0000, 3'd2, 0, 0, 0, 4'b0000, 0, 16'h0050, 0));
    issue(st(2'b11, 3'd0, 4'd0, 3'd3, 16'h0000, 16'h00CC, 4'b0000, 0, 0),
          ex(1, 16'h00CC, 16'h0000, 3'd3, 1, 0, 0, 4'b0000, 0, 16'h0050, 0));

    // Store
    issue(st(2'b01, 3'd0, 4'd0, 3'd7, 16'hBEEF, 16'h1234, 4'b0000, 0, 0),
          ex(1, 16'h1234, 16'hBEEF, 3'd7, 0, 0, 1, 4'b0000, 0, 16'h0050, 0));

    // HLT, one accepted (non-live) slot during drain, then halted
    issue(st(2'b11, 3'd0, 4'd15, 3'd0, 16'h0000, 16'h0000, 4'b1111, 1, 0),
          ex(0, 16'h0000, 16'h0000, 3'd0, 0, 0, 0, 4'b0000, 0, 16'h0050, 1));
    #1;
    chk("drain0_halted", 32'(halted), 32'd0);
    issue(st(2'b11, 3'd0, 4'd0, 3'd1, 16'h0000, 16'h0DDD, 4'b1111, 0, 0),
          ex(0, 16'h0DDD, 16'h0000, 3'd1, 0, 0, 0, 4'b0000, 0, 16'h0050, 1));
    #1;
    chk("drain1_halted", 32'(halted), 32'd0);
    @(posedge clk);
    #2;
    chk("halted", 32'(halted), 32'd1);
    chk("halted_ex_ready", 32'(ex_ready), 32'd0);
    chk("halted_halt_req", 32'(halt_req), 32'd1);
    chk("halted_flags", 32'({flag_s, flag_z, flag_c, flag_v}), 32'd0);

    // A valid slot while halted is never accepted
    drive(st(2'b11, 3'd0, 4'd0, 3'd1, 16'h0000, 16'hEEEE, 4'b1111, 0, 0));
    @(posedge clk);
    #2;
    chk("halted_hold_result", 32'(mem_result), 32'h0DDD);
    chk("halted_hold_flags", 32'({flag_s, flag_z, flag_c, flag_v}), 32'd0);
    ex_valid = 1'b0;

    // Scoreboard must be drained (bounded wait)
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-cycle clears halt immediately
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_halted", 32'(halted), 32'd0);
    chk("async_rst_halt_req", 32'(halt_req), 32'd0);
    chk("async_rst_result", 32'(mem_result), 32'd0);
    chk("async_rst_ex_ready", 32'(ex_ready), 32'd1);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
